rom_readback: RTL
=================

ROM_READBACK -- requirements
Module: rom_readback

Interface
REQ-001 Parameter TOTAL_LEN, default 25'h24A40, number of bytes streamed per dump (global ROM layout 0x00000-0x24A3F).
REQ-002 Parameter RD_LATENCY, default 1, cycles from RD_EN high to valid RD_DATA (range 1-4).
REQ-003 Parameter FIFO_DEPTH, default 4, output buffer entries (SHALL be >= RD_LATENCY+1).
REQ-004 CLK  in  1  single clock; all logic rising-edge.
REQ-005 RESET_n  in  1  synchronous, active-low reset.
REQ-006 START  in  1  one-cycle request to begin a dump.
REQ-007 ABORT  in  1  terminate dump in progress.
REQ-008 RD_ADDR  out  25  global ROM address; external selector decodes the region, and the region's port-B q is muxed onto RD_DATA.
REQ-009 RD_EN  out  1  read strobe for RD_ADDR.
REQ-010 RD_DATA  in  8  returned byte (4-bit PROMs zero-extended externally).
REQ-011 OUT_DATA  out  8  streamed byte.
REQ-012 OUT_VALID  out  1  OUT_DATA valid.
REQ-013 OUT_READY  in  1  sink accepts byte; transfer = OUT_VALID & OUT_READY.
REQ-014 BUSY  out  1  dump in progress.
REQ-015 DONE  out  1  one-cycle pulse on normal completion.
REQ-016 CHECKSUM  out  16  sum mod 2^16 of all transferred bytes of current/last dump.

Function
REQ-017 FSM states IDLE, RUN, DRAIN, FIN; BUSY=1 in RUN and DRAIN only.
REQ-018 IDLE: START=1 and ABORT=0 -> RUN; address counter, CHECKSUM, FIFO, in-flight pipe cleared same edge.
REQ-019 RUN: RD_EN=1 iff counter < TOTAL_LEN and (FIFO occupancy + in-flight reads) < FIFO_DEPTH; RD_ADDR = counter; counter +1 per RD_EN.
REQ-020 RUN -> DRAIN on the edge where the final read (address TOTAL_LEN-1) issues.
REQ-021 RD_DATA sampled exactly RD_LATENCY cycles after each RD_EN and written to FIFO tail, tracked by a RD_LATENCY-deep valid shift pipe.
REQ-022 OUT_VALID = FIFO non-empty; OUT_DATA = FIFO head (registered); pop on transfer; simultaneous push and pop allowed at any occupancy, including full.
REQ-023 Bytes SHALL leave in strictly ascending address order, no loss, no duplication.
REQ-024 CHECKSUM += OUT_DATA on each transfer, 16-bit wrap-around.
REQ-025 DRAIN -> FIN when in-flight pipe empty and FIFO empty; FIN asserts DONE for one cycle then -> IDLE.
REQ-026 Latency (RD_LATENCY=1, OUT_READY=1): START sampled at cycle 0, RD_EN at cycle 1, first OUT_VALID at cycle 3; sustained throughput 1 byte/cycle.
REQ-027 ABORT=1 in RUN/DRAIN/FIN: next state IDLE, FIFO and in-flight pipe flushed, late RD_DATA discarded, DONE not pulsed, CHECKSUM holds partial value.
REQ-028 START while BUSY ignored; START with ABORT in same IDLE cycle: stays IDLE.
REQ-029 RD_EN=0 in IDLE, DRAIN, FIN; OUT_VALID=0 in IDLE.

Reset
REQ-030 RESET_n=0 at any edge, including mid-dump: state IDLE, RD_EN=0, RD_ADDR=0, OUT_VALID=0, OUT_DATA=0, BUSY=0, DONE=0, CHECKSUM=0, FIFO and pipe empty.
REQ-031 Reset has priority over START and ABORT.

Verification
REQ-032 Full dump, OUT_READY=1, memory model byte = addr[7:0]^addr[15:8] -> 0x24A40 bytes in order, first OUT_VALID 3 cycles after START, one DONE pulse, CHECKSUM equals model sum mod 65536.
REQ-033 OUT_READY random 30% duty -> identical byte stream and CHECKSUM as REQ-032; FIFO occupancy + in-flight never exceeds FIFO_DEPTH; RD_LATENCY=3 rerun passes.
REQ-034 Region boundaries: bytes at 0x23FFF/0x24000, 0x247FF/0x24800, 0x24A1F/0x24A20, 0x24A3F delivered correctly; no read of 0x24A40.
REQ-035 ABORT when counter=0x10000 with OUT_READY=0 -> BUSY=0 next cycle, OUT_VALID=0, no DONE; subsequent START yields full correct dump.
REQ-036 RESET_n low one cycle mid-DRAIN -> all outputs at REQ-030 values next cycle; START+ABORT same cycle -> BUSY stays 0.
REQ-037 TOTAL_LEN=1 -> exactly one RD_EN (RD_ADDR=0), one transfer, DONE; START during BUSY has no effect.

Source files
------------

// File: rtl/rom_readback.sv
// rom_readback: streams a contiguous ROM region out as a byte stream.
// Reads are issued only while the output buffer has room for every byte
// already requested. Because of that, a returning byte always has a slot,
// and the sink may apply backpressure at any time.
//
// Handshake: OUT_DATA moves when OUT_VALID and OUT_READY are both high on a
// rising edge. OUT_VALID does not depend on OUT_READY, and OUT_DATA holds
// its value while OUT_VALID is high and OUT_READY is low.
module rom_readback #(
    parameter logic [24:0] TOTAL_LEN  = 25'h24A40,
    parameter int          RD_LATENCY = 1,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        START,
    input  logic        ABORT,
    output logic [24:0] RD_ADDR,
    output logic        RD_EN,
    input  logic [7:0]  RD_DATA,
    output logic [7:0]  OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] CHECKSUM
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t                state_q, state_d;
    logic [24:0]           addr_q, addr_d;
    logic [15:0]           chk_q, chk_d;
    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic [7:0]            mem_q [FIFO_DEPTH];
    logic [7:0]            mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rd_en, push, pop, out_valid;
    int                    in_flight;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Read issue gating, buffer push/pop strobes.
    always_comb begin
        in_flight = 0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            in_flight = in_flight + int'(pipe_q[i]);
        end
        rd_en     = (state_q == RUN) && (addr_q < TOTAL_LEN) &&
                    ((int'(cnt_q) + in_flight) < FIFO_DEPTH);
        push      = pipe_q[RD_LATENCY-1] && ((state_q == RUN) || (state_q == DRAIN));
        out_valid = (cnt_q != '0) && (state_q != IDLE);
        pop       = out_valid && OUT_READY;
    end

    // Next-state, address counter, read pipe, buffer and checksum updates.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        chk_d   = chk_q;
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        pipe_d  = pipe_q;

        // Each bit marks a read still travelling through the ROM.
        pipe_d[0] = rd_en;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        if (rd_en) begin
            addr_d = addr_q + 25'd1;
        end
        if (push) begin
            mem_d[wr_q] = RD_DATA;
            wr_d        = ptr_inc(wr_q);
        end
        if (pop) begin
            rd_d  = ptr_inc(rd_q);
            chk_d = chk_q + {8'd0, mem_q[rd_q]};
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        case (state_q)
            IDLE: begin
                if (START && !ABORT) begin
                    state_d = RUN;
                    addr_d  = '0;
                    chk_d   = '0;
                    wr_d    = '0;
                    rd_d    = '0;
                    cnt_d   = '0;
                    pipe_d  = '0;
                end
            end
            RUN, DRAIN, FIN: begin
                if (ABORT) begin
                    // Flushing the pipe also drops any byte the ROM returns late.
                    state_d = IDLE;
                    wr_d    = '0;
                    rd_d    = '0;
                    cnt_d   = '0;
                    pipe_d  = '0;
                end else if (state_q == RUN) begin
                    if (rd_en && (addr_q == TOTAL_LEN - 25'd1)) begin
                        state_d = DRAIN;
                    end
                end else if (state_q == DRAIN) begin
                    if ((pipe_q == '0) && (cnt_q == '0)) begin
                        state_d = FIN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            chk_q   <= '0;
            pipe_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            chk_q   <= chk_d;
            pipe_q  <= pipe_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Buffer storage; contents are only observed through OUT_DATA when valid.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    assign RD_ADDR   = addr_q;
    assign RD_EN     = rd_en;
    assign OUT_VALID = out_valid;
    assign OUT_DATA  = out_valid ? mem_q[rd_q] : 8'd0;
    assign BUSY      = (state_q == RUN) || (state_q == DRAIN);
    assign DONE      = (state_q == FIN) && !ABORT;
    assign CHECKSUM  = chk_q;
endmodule
